cgra_config_sequencer: RTL and testbench

CGRA_CONFIG_SEQUENCER -- requirements
Module: cgra_config_sequencer

---
 rtl/cgra_cfg_pkg.sv | 32 +++
 rtl/cgra_cycle_counter.sv | 39 +++
 rtl/cgra_config_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_cgra_config_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration sequencer: bus widths,
// the session state encoding and the saturating word-count helper.
package cgra_cfg_pkg;

    localparam int CFG_ADDR_W  = 32;
    localparam int CFG_DATA_W  = 32;
    localparam int CFG_COUNT_W = 16;
    localparam int RUN_COUNT_W = 32;

    // Session states of the sequencer
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_CGRA = 3'd1,
        ST_CONFIG     = 3'd2,
        ST_RUN        = 3'd3,
        ST_DONE       = 3'd4
    } cgra_state_e;

    // Increment a config word count, sticking at all-ones instead of wrapping
    function automatic logic [CFG_COUNT_W-1:0] sat_inc_count(
        input logic [CFG_COUNT_W-1:0] value
    );
        logic [CFG_COUNT_W-1:0] result;
        if (value == {CFG_COUNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + CFG_COUNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/cgra_cycle_counter.sv
// Loadable up-counter with a terminal-count flag. Used by the sequencer to
// time both the fabric reset phase and the run phase.
module cgra_cycle_counter
    import cgra_cfg_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             srst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    input  logic [WIDTH-1:0] terminal,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    logic [WIDTH-1:0] count_r;

    // Count register: clear beats load, load beats increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (srst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (en) begin
            count_r <= count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count       = count_r;
    assign at_terminal = (count_r == terminal);

endmodule

// File: rtl/cgra_config_sequencer.sv
// Drives a CGRA fabric through one session: hold the fabric in reset, stream
// the configuration bitstream into it, let it run for a fixed number of
// cycles and then report completion. Abort or reset drops the session.
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int unsigned RESET_CYCLES   = 4,
    parameter int unsigned MAX_RUN_CYCLES = 10000
) (
    input  logic                   clk_in,
    input  logic                   reset_n_in,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic                   cfg_valid_in,
    output logic                   cfg_ready_out,
    input  logic [CFG_ADDR_W-1:0]  cfg_addr_in,
    input  logic [CFG_DATA_W-1:0]  cfg_data_in,
    input  logic                   cfg_last_in,
    output logic                   cgra_reset_out,
    output logic [CFG_ADDR_W-1:0]  config_addr_out,
    output logic [CFG_DATA_W-1:0]  config_data_out,
    output logic                   run_out,
    output logic                   done_out,
    output logic [CFG_COUNT_W-1:0] config_count_out,
    output logic [RUN_COUNT_W-1:0] run_count_out
);

    // Terminal values: the counters start at 0, so the last phase cycle is N-1
    localparam logic [RUN_COUNT_W-1:0] RESET_TC    = RUN_COUNT_W'(RESET_CYCLES - 1);
    localparam logic [RUN_COUNT_W-1:0] RESET_LIMIT = RUN_COUNT_W'(RESET_CYCLES);
    localparam logic [RUN_COUNT_W-1:0] RUN_TC      = RUN_COUNT_W'(MAX_RUN_CYCLES - 1);

    cgra_state_e              state_r;
    cgra_state_e              state_nxt_s;
    logic                     start_go_s;
    logic                     accept_s;
    logic [RUN_COUNT_W-1:0]   rst_count_s;
    logic                     rst_at_tc_s;
    logic                     rst_tc_s;
    logic [RUN_COUNT_W-1:0]   run_count_s;
    logic                     run_tc_s;
    logic                     cgra_reset_r;
    logic                     cfg_ready_r;
    logic                     run_r;
    logic                     done_r;
    logic [CFG_ADDR_W-1:0]    config_addr_r;
    logic [CFG_DATA_W-1:0]    config_data_r;
    logic [CFG_COUNT_W-1:0]   config_count_r;

    // A start is only honoured from IDLE or DONE, and never alongside abort
    assign start_go_s = start_in && !abort_in &&
                        ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // A word is taken only in CONFIG; an abort in the same cycle discards it
    assign accept_s = cfg_valid_in && (state_r == ST_CONFIG) && !abort_in;

    // The range guard stops a corrupted reset counter from ending the phase
    assign rst_tc_s = rst_at_tc_s && (rst_count_s < RESET_LIMIT);

    cgra_cycle_counter #(
        .WIDTH (RUN_COUNT_W)
    ) u_reset_counter (
        .clk         (clk_in),
        .rst_n       (reset_n_in),
        .srst        (abort_in),
        .load        (start_go_s),
        .load_value  ({RUN_COUNT_W{1'b0}}),
        .en          (state_r == ST_RESET_CGRA),
        .terminal    (RESET_TC),
        .count       (rst_count_s),
        .at_terminal (rst_at_tc_s)
    );

    cgra_cycle_counter #(
        .WIDTH (RUN_COUNT_W)
    ) u_run_counter (
        .clk         (clk_in),
        .rst_n       (reset_n_in),
        .srst        (abort_in),
        .load        (start_go_s),
        .load_value  ({RUN_COUNT_W{1'b0}}),
        .en          (state_r == ST_RUN),
        .terminal    (RUN_TC),
        .count       (run_count_s),
        .at_terminal (run_tc_s)
    );

    // Next-state selection; abort overrides every other transition
    always_comb begin
        state_nxt_s = state_r;
        if (abort_in) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_in) begin
                        state_nxt_s = ST_RESET_CGRA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RESET_CGRA: begin
                    if (rst_tc_s) begin
                        state_nxt_s = ST_CONFIG;
                    end else begin
                        state_nxt_s = ST_RESET_CGRA;
                    end
                end
                ST_CONFIG: begin
                    if (accept_s && cfg_last_in) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_CONFIG;
                    end
                end
                ST_RUN: begin
                    if (run_tc_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (start_in) begin
                        state_nxt_s = ST_RESET_CGRA;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Status flags are registered from the next state so they line up with it
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cgra_reset_r <= 1'b0;
            cfg_ready_r  <= 1'b0;
            run_r        <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            cgra_reset_r <= (state_nxt_s == ST_RESET_CGRA);
            cfg_ready_r  <= (state_nxt_s == ST_CONFIG);
            run_r        <= (state_nxt_s == ST_RUN);
            done_r       <= (state_nxt_s == ST_DONE);
        end
    end

    // Config word pipeline: an accepted word is shown for one cycle, else zero
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            config_addr_r <= {CFG_ADDR_W{1'b0}};
            config_data_r <= {CFG_DATA_W{1'b0}};
        end else if (accept_s) begin
            config_addr_r <= cfg_addr_in;
            config_data_r <= cfg_data_in;
        end else begin
            config_addr_r <= {CFG_ADDR_W{1'b0}};
            config_data_r <= {CFG_DATA_W{1'b0}};
        end
    end

    // Accepted-word count for the session, cleared on abort or a new session
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            config_count_r <= {CFG_COUNT_W{1'b0}};
        end else if (abort_in || start_go_s) begin
            config_count_r <= {CFG_COUNT_W{1'b0}};
        end else if (accept_s) begin
            config_count_r <= sat_inc_count(config_count_r);
        end else begin
            config_count_r <= config_count_r;
        end
    end

    assign cgra_reset_out   = cgra_reset_r;
    assign cfg_ready_out    = cfg_ready_r;
    assign run_out          = run_r;
    assign done_out         = done_r;
    assign config_addr_out  = config_addr_r;
    assign config_data_out  = config_data_r;
    assign config_count_out = config_count_r;
    assign run_count_out    = run_count_s;

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Self-checking bench for cgra_config_sequencer with RESET_CYCLES=4 and
// MAX_RUN_CYCLES=10. Expected fabric words are queued as stimulus is driven
// and popped after each clock edge.
module tb_cgra_config_sequencer;

    localparam int RC = 4;
    localparam int MR = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_data;
    logic        cfg_last;
    logic        cgra_reset;
    logic [31:0] config_addr;
    logic [31:0] config_data;
    logic        run;
    logic        done;
    logic [15:0] config_count;
    logic [31:0] run_count;

    int          assert_cnt = 0;
    int          fail_cnt   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_word;

    cgra_config_sequencer #(
        .RESET_CYCLES   (RC),
        .MAX_RUN_CYCLES (MR)
    ) dut (
        .clk_in           (clk),
        .reset_n_in       (reset_n),
        .start_in         (start),
        .abort_in         (abort),
        .cfg_valid_in     (cfg_valid),
        .cfg_ready_out    (cfg_ready),
        .cfg_addr_in      (cfg_addr),
        .cfg_data_in      (cfg_data),
        .cfg_last_in      (cfg_last),
        .cgra_reset_out   (cgra_reset),
        .config_addr_out  (config_addr),
        .config_data_out  (config_data),
        .run_out          (run),
        .done_out         (done),
        .config_count_out (config_count),
        .run_count_out    (run_count)
    );

    always #5 clk = ~clk;

    function automatic logic [115:0] all_outs();
        return {cfg_ready, cgra_reset, run, done, config_addr, config_data,
                config_count, run_count};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        abort     = 1'b0;
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_addr  = 32'd0;
        cfg_data  = 32'd0;
    endtask

    // Offer a word and queue what the fabric port must show after the edge
    task automatic offer(input logic [31:0] a, input logic [31:0] d,
                         input logic last, input logic will_accept);
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = last;
        exp_q.push_back(will_accept ? {a, d} : 64'd0);
    endtask

    task automatic no_offer();
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
        cfg_addr  = 32'd0;
        cfg_data  = 32'd0;
        exp_q.push_back(64'd0);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        cfg_valid = 1'b1;
        cfg_addr  = 32'hDEAD_BEEF;
        step();
        step();
        assert_cnt++;
        if (all_outs() !== 116'd0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        reset_n = 1'b1;
        step();
        step();
        assert_cnt++;
        if (all_outs() !== 116'd0) begin
            fail_cnt++;
            $display("FAIL idle_outputs: got %h required 0", all_outs());
        end
        idle_inputs();
    endtask

    // Start a session and time the fabric reset; optionally poke start mid-phase
    task automatic test_reset_phase(input string tag, input bit poke_start);
        int hi;
        start = 1'b1;
        step();
        start = 1'b0;
        assert_cnt++;
        if (config_count !== 16'd0 || run_count !== 32'd0 || done !== 1'b0) begin
            fail_cnt++;
            $display("FAIL %s_counts_clear: got cc=%0d rc=%0d done=%b required 0/0/0",
                     tag, config_count, run_count, done);
        end
        hi = 0;
        while (cgra_reset === 1'b1 && hi < 20) begin
            hi++;
            if (cfg_ready !== 1'b0) begin
                assert_cnt++;
                fail_cnt++;
                $display("FAIL %s_ready_in_reset: got %b required 0", tag, cfg_ready);
            end
            start = (poke_start && hi == 2) ? 1'b1 : 1'b0;
            step();
        end
        start = 1'b0;
        assert_cnt++;
        if (hi != RC) begin
            fail_cnt++;
            $display("FAIL %s_reset_len: got %0d required %0d", tag, hi, RC);
        end
        assert_cnt++;
        if (cfg_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s_ready_after_reset: got %b required 1", tag, cfg_ready);
        end
    endtask

    task automatic test_config_stream();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        addrs = '{32'h0001_0001, 32'h0002_0002, 32'h0003_0003};
        datas = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hC3C3_0003};
        for (int i = 0; i < 3; i++) begin
            offer(addrs[i], datas[i], (i == 2), 1'b1);
            step();
            exp_word = exp_q.pop_front();
            assert_cnt++;
            if ({config_addr, config_data} !== exp_word) begin
                fail_cnt++;
                $display("FAIL stream_word%0d: got %h required %h", i,
                         {config_addr, config_data}, exp_word);
            end
            assert_cnt++;
            if (config_count !== 16'(i + 1)) begin
                fail_cnt++;
                $display("FAIL stream_count%0d: got %0d required %0d", i, config_count, i + 1);
            end
        end
        assert_cnt++;
        if (run !== 1'b1 || cfg_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL stream_run_after_last: got run=%b ready=%b required 1/0", run, cfg_ready);
        end
        no_offer();
        step();
        exp_word = exp_q.pop_front();
        assert_cnt++;
        if ({config_addr, config_data} !== exp_word || config_count !== 16'd3) begin
            fail_cnt++;
            $display("FAIL stream_trailing_zero: got %h cc=%0d required %h cc=3",
                     {config_addr, config_data}, config_count, exp_word);
        end
    endtask

    // Count RUN cycles starting from the current sample (index first_idx)
    task automatic test_run_done(input int first_idx, input int exp_cc);
        int k;
        k = first_idx;
        while (run === 1'b1 && k < 50) begin
            if (run_count !== 32'(k)) begin
                assert_cnt++;
                fail_cnt++;
                $display("FAIL run_count_at%0d: got %0d required %0d", k, run_count, k);
            end
            start = (k == 3) ? 1'b1 : 1'b0;
            k++;
            step();
        end
        start = 1'b0;
        assert_cnt++;
        if (k != MR) begin
            fail_cnt++;
            $display("FAIL run_length: got %0d required %0d", k, MR);
        end
        assert_cnt++;
        if (done !== 1'b1 || run !== 1'b0 || run_count !== 32'(MR) || config_count !== 16'(exp_cc)) begin
            fail_cnt++;
            $display("FAIL done_state: got done=%b run=%b rc=%0d cc=%0d required 1/0/%0d/%0d",
                     done, run, run_count, config_count, MR, exp_cc);
        end
        offer(32'h0BAD_0BAD, 32'h1234_5678, 1'b1, 1'b0);
        step();
        step();
        no_offer();
        exp_word = exp_q.pop_front();
        exp_word = exp_q.pop_front();
        assert_cnt++;
        if ({config_addr, config_data} !== exp_word || cfg_ready !== 1'b0 ||
            done !== 1'b1 || run_count !== 32'(MR)) begin
            fail_cnt++;
            $display("FAIL done_hold: got w=%h ready=%b done=%b rc=%0d required 0/0/1/%0d",
                     {config_addr, config_data}, cfg_ready, done, run_count, MR);
        end
        idle_inputs();
    endtask

    task automatic test_config_gaps();
        logic        pat [6];
        int          exp_cc;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        exp_cc = 0;
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) begin
                offer(32'h0100_0000 + 32'(i), 32'hF000_0000 | 32'(i * 7), (i == 5), 1'b1);
                exp_cc++;
            end else begin
                no_offer();
            end
            step();
            exp_word = exp_q.pop_front();
            assert_cnt++;
            if ({config_addr, config_data} !== exp_word || config_count !== 16'(exp_cc)) begin
                fail_cnt++;
                $display("FAIL gap_cycle%0d: got w=%h cc=%0d required w=%h cc=%0d", i,
                         {config_addr, config_data}, config_count, exp_word, exp_cc);
            end
        end
        assert_cnt++;
        if (run !== 1'b1) begin
            fail_cnt++;
            $display("FAIL gap_run_entry: got %b required 1", run);
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        step();
        step();
        #2;
        reset_n = 1'b0;
        #1;
        assert_cnt++;
        if (all_outs() !== 116'd0) begin
            fail_cnt++;
            $display("FAIL async_reset_immediate: got %h required 0", all_outs());
        end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            assert_cnt++;
            if (all_outs() !== 116'd0) begin
                fail_cnt++;
                $display("FAIL after_reset_idle%0d: got %h required 0", i, all_outs());
            end
        end
    endtask

    task automatic test_abort();
        offer(32'h0000_AAAA, 32'h0000_5555, 1'b0, 1'b1);
        step();
        exp_word = exp_q.pop_front();
        assert_cnt++;
        if ({config_addr, config_data} !== exp_word || config_count !== 16'd1) begin
            fail_cnt++;
            $display("FAIL abort_pre_word: got w=%h cc=%0d required w=%h cc=1",
                     {config_addr, config_data}, config_count, exp_word);
        end
        offer(32'h0000_BBBB, 32'h0000_6666, 1'b0, 1'b0);
        abort = 1'b1;
        start = 1'b1;
        step();
        exp_word = exp_q.pop_front();
        assert_cnt++;
        if ({config_addr, config_data} !== exp_word || all_outs() !== 116'd0) begin
            fail_cnt++;
            $display("FAIL abort_with_accept: got %h required 0", all_outs());
        end
        idle_inputs();
        step();
        assert_cnt++;
        if (all_outs() !== 116'd0) begin
            fail_cnt++;
            $display("FAIL abort_stays_idle: got %h required 0", all_outs());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_phase("s1", 1'b0);
        test_config_stream();
        test_run_done(1, 3);
        test_reset_phase("s2", 1'b1);
        test_config_gaps();
        test_async_reset();
        test_reset_phase("s3", 1'b0);
        test_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
